// File: rtl/transmitter_hs_if.sv
// Word-transfer link bundle: memory read port, Req/Ack handshake and frame status.
interface transmitter_hs_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              Start;
   logic [ADDR_W-1:0] Address;
   logic              ReadEnable;
   logic [DATA_W-1:0] DataOut;
   logic [DATA_W-1:0] Saida;
   logic              Req;
   logic              Ack;
   logic              Busy;
   logic              Done;
   logic              Error;

   modport master (
      input  Start, DataOut, Ack,
      output Address, ReadEnable, Saida, Req, Busy, Done, Error
   );

   modport slave (
      output Start, DataOut, Ack,
      input  Address, ReadEnable, Saida, Req, Busy, Done, Error
   );
endinterface

// File: rtl/transmitter_hs.sv
// Sending end of the 4-phase Req/Ack link: reads NWORDS words from a sync-read
// memory and hands each one to the receiver under a full Req/Ack handshake.
module transmitter_hs #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 4,
   parameter int NWORDS      = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 0
) (
   input logic              Clock,
   input logic              Reset,
   transmitter_hs_if.master bus
);
   localparam int TW = $clog2(TIMEOUT + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_REQ,
      S_WAIT_LOW,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                 state, state_next;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic                   fetched;
   logic [TW-1:0]          tmr;
   logic                   timed_out;
   logic                   last;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ack_sync <= '0;
      end else begin
         ack_sync[0] <= bus.Ack;
         for (int unsigned i = 1; i < SYNC_STAGES; i++)
            ack_sync[i] <= ack_sync[i-1];
      end
   end

   assign ack_s     = ack_sync[SYNC_STAGES-1];
   assign timed_out = (TIMEOUT != 0) && (tmr == TW'(TIMEOUT));
   assign last      = (bus.Address == ADDR_W'(NWORDS - 1));

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // REQ only accepts Ack_s once Req is actually on the wire, so a stray Ack
   // arriving in the cycle Req is being raised cannot complete the handshake.
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:     if (bus.Start) state_next = S_READ;
         S_READ:     state_next = S_LOAD;
         S_LOAD:     if (!ack_s) state_next = S_REQ;
         S_REQ: begin
            if (bus.Req && ack_s) state_next = S_WAIT_LOW;
            else if (timed_out)   state_next = S_ERROR;
         end
         S_WAIT_LOW: begin
            if (!ack_s)         state_next = last ? S_DONE : S_READ;
            else if (timed_out) state_next = S_ERROR;
         end
         S_DONE:     state_next = S_IDLE;
         S_ERROR:    state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         bus.Address    <= '0;
         bus.ReadEnable <= 1'b0;
         bus.Saida      <= '0;
         bus.Req        <= 1'b0;
         bus.Busy       <= 1'b0;
         bus.Done       <= 1'b0;
         bus.Error      <= 1'b0;
         fetched        <= 1'b0;
         tmr            <= '0;
      end else begin
         if (state == S_IDLE && state_next == S_READ)
            bus.Address <= '0;
         else if (state == S_WAIT_LOW && state_next == S_READ)
            bus.Address <= bus.Address + ADDR_W'(1);
         else if (state == S_ERROR)
            bus.Address <= '0;

         bus.ReadEnable <= (state_next == S_READ);
         bus.Req        <= (state == S_REQ) && (state_next == S_REQ);
         bus.Busy       <= (state_next != S_IDLE);
         bus.Done       <= (state_next == S_DONE);
         bus.Error      <= (state_next == S_ERROR);

         // Memory data is valid only in the first LOAD cycle; later LOAD cycles hold it.
         fetched <= (state == S_READ);
         if (state == S_LOAD && fetched)
            bus.Saida <= bus.DataOut;

         if (state_next != state && (state_next == S_REQ || state_next == S_WAIT_LOW))
            tmr <= '0;
         else if ((state == S_REQ || state == S_WAIT_LOW) && !timed_out)
            tmr <= tmr + TW'(1);
      end
   end
endmodule

// File: tb/tb_transmitter_hs.sv
// Directed bench for transmitter_hs: scoreboard of expected link words, checked
// against words captured at each Req rise, plus frame status and timing checks.
module tb_transmitter_hs;
   logic Clock = 1'b0;
   logic Reset = 1'b1;

   always #5 Clock = ~Clock;

   transmitter_hs_if #(.DATA_W(16), .ADDR_W(4)) bus ();
   transmitter_hs_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();

   transmitter_hs #(
      .DATA_W(16), .ADDR_W(4), .NWORDS(16), .SYNC_STAGES(2), .TIMEOUT(32)
   ) dut (
      .Clock(Clock), .Reset(Reset), .bus(bus.master)
   );

   transmitter_hs #(
      .DATA_W(16), .ADDR_W(4), .NWORDS(1), .SYNC_STAGES(2), .TIMEOUT(0)
   ) dut_one (
      .Clock(Clock), .Reset(Reset), .bus(bus1.master)
   );

   int checks = 0;
   int errors = 0;

   // memories: mem[i] = A000 + i
   always @(posedge Clock) if (bus.ReadEnable)  bus.DataOut  <= 16'hA000 + 16'(bus.Address);
   always @(posedge Clock) if (bus1.ReadEnable) bus1.DataOut <= 16'hA000 + 16'(bus1.Address);

   // responder: Ack 2 cycles after Req rises, drop 2 cycles after Req falls
   logic resp_en = 1'b0;
   logic man_ack = 1'b0;
   logic r_ack   = 1'b0;
   int   rc      = 0;
   assign bus.Ack = resp_en ? r_ack : man_ack;

   always @(posedge Clock) begin
      if (!resp_en) begin
         r_ack <= 1'b0; rc <= 0;
      end else if (bus.Req != r_ack) begin
         if (rc == 1) begin r_ack <= bus.Req; rc <= 0; end
         else rc <= rc + 1;
      end else rc <= 0;
   end

   logic r_ack1 = 1'b0;
   int   rc1    = 0;
   assign bus1.Ack = r_ack1;

   always @(posedge Clock) begin
      if (bus1.Req != r_ack1) begin
         if (rc1 == 1) begin r_ack1 <= bus1.Req; rc1 <= 0; end
         else rc1 <= rc1 + 1;
      end else rc1 <= 0;
   end

   // monitors
   logic [15:0] obs[$];
   logic [15:0] obs1[$];
   logic [15:0] exp_q[$];
   logic        req_q = 1'b0, busy_q = 1'b0, saida_bad = 1'b0;
   logic [15:0] saida_q = '0;
   int rises = 0, req_run = 0, req_len = 0, done_n = 0, err_n = 0;
   int busy_low_run = 0, busy_gap = 0;
   logic req1_q = 1'b0, addr1_bad = 1'b0;
   int rises1 = 0, done1_n = 0;

   always @(negedge Clock) begin
      req_q   <= bus.Req;
      saida_q <= bus.Saida;
      busy_q  <= bus.Busy;
      if (bus.Req && !req_q) begin
         obs.push_back(bus.Saida);
         rises <= rises + 1;
      end
      if (bus.Req && req_q && bus.Saida !== saida_q) saida_bad <= 1'b1;
      if (bus.Req) req_run <= req_run + 1;
      else begin
         if (req_q) req_len <= req_run;
         req_run <= 0;
      end
      if (bus.Done)  done_n <= done_n + 1;
      if (bus.Error) err_n  <= err_n + 1;
      if (!bus.Busy) busy_low_run <= busy_low_run + 1;
      else begin
         if (!busy_q) busy_gap <= busy_low_run;
         busy_low_run <= 0;
      end
   end

   always @(negedge Clock) begin
      req1_q <= bus1.Req;
      if (bus1.Req && !req1_q) begin
         obs1.push_back(bus1.Saida);
         rises1 <= rises1 + 1;
      end
      if (bus1.Done) done1_n <= done1_n + 1;
      if (!Reset && bus1.Address !== 4'd0) addr1_bad <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      checks++;
      assert (obs_v === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge Clock); #1; end
   endtask

   task automatic push_frame(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(16'hA000 + 16'(i % 16));
   endtask

   task automatic check_words(input string tag);
      while (exp_q.size() > 0) begin
         if (obs.size() == 0) begin
            check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
         end else begin
            check({tag, "_word"}, 32'(obs.pop_front()), 32'(exp_q.pop_front()));
         end
      end
      check({tag, "_extra"}, 32'(obs.size()), 32'd0);
      obs.delete();
   endtask

   task automatic wait_done(input int target, input string tag);
      int n = 0;
      while (done_n < target && n < 3000) begin tick(1); n++; end
      check({tag, "_done_seen"}, 32'(done_n >= target), 32'd1);
   endtask

   task automatic start_latency(input string tag);
      int lat = 0;
      for (int k = 1; k <= 12 && lat == 0; k++) begin
         tick(1);
         if (k == 1) bus.Start = 1'b0;
         if (bus.Req) lat = k;
      end
      check(tag, 32'(lat), 32'd4);
   endtask

   initial begin
      int r0, d0, e0, n;
      bus.Start  = 1'b0;
      bus1.Start = 1'b0;

      // reset state
      tick(3);
      check("rst_address", 32'(bus.Address), 32'd0);
      check("rst_re",      32'(bus.ReadEnable), 32'd0);
      check("rst_saida",   32'(bus.Saida), 32'd0);
      check("rst_req",     32'(bus.Req), 32'd0);
      check("rst_busy",    32'(bus.Busy), 32'd0);
      check("rst_done",    32'(bus.Done), 32'd0);
      check("rst_error",   32'(bus.Error), 32'd0);
      Reset = 1'b0;
      tick(2);

      // 1: full frame with responder
      resp_en = 1'b1;
      push_frame(16);
      d0 = done_n; e0 = err_n;
      bus.Start = 1'b1;
      start_latency("t1_start_to_req");
      wait_done(d0 + 1, "t1");
      check("t1_busy_after", 32'(bus.Busy), 32'd0);
      check_words("t1");
      tick(5);
      check("t1_one_done", 32'(done_n), 32'(d0 + 1));
      check("t1_no_error", 32'(err_n), 32'(e0));
      check("t1_saida_stable", 32'(saida_bad), 32'd0);

      // 2: Ack held high across Start
      resp_en = 1'b0; man_ack = 1'b1;
      tick(5);
      r0 = rises; d0 = done_n;
      push_frame(16);
      bus.Start = 1'b1;
      tick(1);
      bus.Start = 1'b0;
      tick(20);
      check("t2_no_req_rise", 32'(rises - r0), 32'd0);
      check("t2_req_low",     32'(bus.Req), 32'd0);
      check("t2_busy",        32'(bus.Busy), 32'd1);
      man_ack = 1'b0; resp_en = 1'b1;
      n = 0;
      for (int k = 1; k <= 12 && n == 0; k++) begin tick(1); if (bus.Req) n = k; end
      check("t2_ack_low_to_req", 32'(n), 32'd4);
      wait_done(d0 + 1, "t2");
      check_words("t2");

      // 3: no acknowledge -> timeout abort
      resp_en = 1'b0; man_ack = 1'b0;
      d0 = done_n; e0 = err_n;
      push_frame(1);
      bus.Start = 1'b1;
      tick(1);
      bus.Start = 1'b0;
      n = 0;
      while (err_n == e0 && n < 300) begin tick(1); n++; end
      check("t3_error_seen", 32'(err_n > e0), 32'd1);
      check("t3_req_len",    32'(req_len), 32'd32);
      check("t3_req_low",    32'(bus.Req), 32'd0);
      check("t3_busy_low",   32'(bus.Busy), 32'd0);
      tick(5);
      check("t3_one_error",  32'(err_n), 32'(e0 + 1));
      check("t3_no_done",    32'(done_n), 32'(d0));
      check_words("t3");

      // 4: reset while Req is high on word 5
      resp_en = 1'b1;
      r0 = rises;
      push_frame(6);
      bus.Start = 1'b1;
      tick(1);
      bus.Start = 1'b0;
      n = 0;
      while (rises < r0 + 6 && n < 1000) begin tick(1); n++; end
      check("t4_req_before_reset", 32'(bus.Req), 32'd1);
      check("t4_address5",         32'(bus.Address), 32'd5);
      #3 Reset = 1'b1;
      #1;
      check("t4_async_req",     32'(bus.Req), 32'd0);
      check("t4_async_busy",    32'(bus.Busy), 32'd0);
      check("t4_async_address", 32'(bus.Address), 32'd0);
      @(posedge Clock); #1;
      Reset = 1'b0;
      tick(10);
      check_words("t4_partial");
      d0 = done_n;
      push_frame(16);
      bus.Start = 1'b1;
      tick(1);
      bus.Start = 1'b0;
      wait_done(d0 + 1, "t4");
      check_words("t4_restart");

      // 5: Start held high -> two back-to-back frames
      d0 = done_n;
      push_frame(32);
      bus.Start = 1'b1;
      wait_done(d0 + 2, "t5");
      bus.Start = 1'b0;
      tick(5);
      check("t5_two_done",  32'(done_n), 32'(d0 + 2));
      check("t5_idle_gap",  32'(busy_gap), 32'd1);
      check("t5_busy_low",  32'(bus.Busy), 32'd0);
      check_words("t5");

      // 6: single-word frame
      d0 = done1_n;
      bus1.Start = 1'b1;
      tick(1);
      bus1.Start = 1'b0;
      n = 0;
      while (done1_n == d0 && n < 300) begin tick(1); n++; end
      check("t6_done",       32'(done1_n), 32'(d0 + 1));
      check("t6_one_word",   32'(obs1.size()), 32'd1);
      if (obs1.size() > 0) check("t6_word", 32'(obs1.pop_front()), 32'h0000A000);
      check("t6_addr_zero",  32'(addr1_bad), 32'd0);
      check("t6_busy_low",   32'(bus1.Busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
